// File: rtl/fetch_bundle_queue.sv
// Fetch bundle queue: decouples IF2 (I-cache data, BTB, fetch exceptions) from predecode.
// Latency: write in cycle N is visible at the head in N+1; 0 cycles via the empty-queue bypass when enabled.
// Backpressure: pd_busy_i holds the head; if_stall_o throttles fetch early; writes into a full queue are dropped (overflow_o).
//
// Optional feature macro: FETCH_BUFFER_BYPASS_EN (empty-queue same-cycle bypass to the head outputs).
//
// Ports:
//   cpu_clk_i / cpu_rst_n_i        core clock, async active-low reset
//   flush_i                        empties the queue in one cycle, discards that cycle's write
//   if_*_i                         incoming fetch bundle (instruction, PC, exception, BTB metadata)
//   if_stall_o                     occupancy >= AFULL_THRESH (registered state only)
//   overflow_o                     one-cycle pulse after a write was dropped because the queue was full
//   count_o                        current occupancy
//   valid_o + head fields          head bundle presented to predecode
//   pd_busy_i                      predecode cannot accept; head is held
module fetch_bundle_queue #(
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 2
) (
    input  logic                       cpu_clk_i,
    input  logic                       cpu_rst_n_i,
    input  logic                       flush_i,
    input  logic                       if_valid_i,
    input  logic [63:0]                if_instruction_i,
    input  logic [31:0]                if_vpc_i,
    input  logic                       if_excp_vld_i,
    input  logic [3:0]                 if_excp_code_i,
    input  logic                       if_btb_index_i,
    input  logic                       if_btb_way_i,
    input  logic [1:0]                 if_btb_btype_i,
    input  logic [1:0]                 if_btb_bm_pred_i,
    input  logic [31:0]                if_btb_target_i,
    input  logic                       if_btb_vld_i,
    output logic                       if_stall_o,
    output logic                       overflow_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       valid_o,
    output logic [63:0]                instruction_o,
    output logic [31:0]                vpc_o,
    output logic                       excp_vld_o,
    output logic [3:0]                 excp_code_o,
    output logic                       btb_index_o,
    output logic                       btb_way_o,
    output logic [1:0]                 btb_btype_o,
    output logic [1:0]                 btb_bm_pred_o,
    output logic [31:0]                btb_target_o,
    output logic                       btb_vld_o,
    input  logic                       pd_busy_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 140;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic [EW-1:0] mem_q [DEPTH];

    logic          empty, full;
    logic          wr_en, rd_en;
    logic          byp_act, byp_consume;
    logic [EW-1:0] in_entry, head_entry, out_entry;

    assign in_entry = {if_instruction_i, if_vpc_i, if_btb_target_i, if_btb_btype_i,
                       if_btb_bm_pred_i, if_btb_vld_i, if_excp_vld_i, if_excp_code_i,
                       if_btb_index_i, if_btb_way_i};

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign head_entry = mem_q[rd_ptr_q[AW-1:0]];

`ifdef FETCH_BUFFER_BYPASS_EN
    // Empty queue: the incoming bundle is presented directly; stored only if predecode is busy.
    assign byp_act     = empty & if_valid_i & ~flush_i;
    assign byp_consume = byp_act & ~pd_busy_i;
`else
    assign byp_act     = 1'b0;
    assign byp_consume = 1'b0;
`endif

    assign wr_en = if_valid_i & ~full & ~flush_i & ~byp_consume;
    // A pop during flush is meaningless; the flush already resets both pointers.
    assign rd_en = ~empty & ~pd_busy_i & ~flush_i;

    // Dropped writes are only those rejected for lack of space, not those killed by flush.
    assign overflow_d = if_valid_i & full & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge cpu_clk_i or negedge cpu_rst_n_i) begin
        if (!cpu_rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is cleared on reset so the head fields read zero while empty after reset.
    always_ff @(posedge cpu_clk_i or negedge cpu_rst_n_i) begin
        if (!cpu_rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_entry;
        end
    end

    assign out_entry = byp_act ? in_entry : head_entry;

    assign {instruction_o, vpc_o, btb_target_o, btb_btype_o, btb_bm_pred_o,
            btb_vld_o, excp_vld_o, excp_code_o, btb_index_o, btb_way_o} = out_entry;

    assign valid_o    = ~empty | byp_act;
    assign count_o    = wr_ptr_q - rd_ptr_q;
    assign if_stall_o = (count_o >= PW'(AFULL_THRESH));
    assign overflow_o = overflow_q;

endmodule
